// File: rtl/mem_arbiter_if.sv
// Signal bundle between the core's fetch/load-store ports, the arbiter and the word array.
// The arbiter uses the slave view. Requesters and the array model use the master view.
interface mem_arbiter_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ADDR_LEN = 10
);
  logic                  i_req;
  logic [XLEN-1:0]       i_addr;
  logic                  i_ack;
  logic                  i_err;
  logic [XLEN-1:0]       i_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [XLEN/8-1:0]     d_be;
  logic [XLEN-1:0]       d_addr;
  logic [XLEN-1:0]       d_wdata;
  logic                  d_ack;
  logic                  d_err;
  logic [XLEN-1:0]       d_rdata;

  logic [ADDR_LEN-1:0]   mem_addr;
  logic [XLEN-1:0]       mem_wdata;
  logic                  mem_cs_n;
  logic                  mem_we_n;
  logic [XLEN-1:0]       mem_rdata;

  logic                  busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    output i_ack, i_err, i_rdata, d_ack, d_err, d_rdata,
           mem_addr, mem_wdata, mem_cs_n, mem_we_n, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_err, i_rdata, d_ack, d_err, d_rdata,
           mem_addr, mem_wdata, mem_cs_n, mem_we_n, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that turns fetch (I) and load/store (D) requests into one-cycle
// commands to a single-port read-then-commit word array.
module mem_arbiter #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ADDR_LEN = 10
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  localparam int unsigned NBE = XLEN / 8;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic {PORT_I, PORT_D} port_t;

  state_t          state;
  port_t           last_grant;
  port_t           owner;
  logic            err_q;
  logic [XLEN-1:0] wdata_q;
  logic [NBE-1:0]  be_q;

  logic            grant_d;
  logic [XLEN-1:0] req_addr;
  logic            req_err;
  logic            req_store;
  logic            req_full;

  always_comb begin
    grant_d   = bus.d_req && (!bus.i_req || (last_grant == PORT_I));
    req_addr  = grant_d ? bus.d_addr : bus.i_addr;
    req_err   = (req_addr[1:0] != 2'b00) || (req_addr[XLEN-1:ADDR_LEN+2] != '0);
    req_store = grant_d && bus.d_we;
    req_full  = req_store && (bus.d_be == '1) && !req_err;
  end

  // Every selected cycle commits. Unselected lanes write back what was just read.
  always_comb begin
    bus.mem_wdata = bus.mem_rdata;
    for (int unsigned k = 0; k < NBE; k++) begin
      if (be_q[k]) begin
        bus.mem_wdata[8*k +: 8] = wdata_q[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= PORT_D;
      owner        <= PORT_I;
      err_q        <= 1'b0;
      wdata_q      <= '0;
      be_q         <= '0;
      bus.mem_cs_n <= 1'b1;
      bus.mem_we_n <= 1'b1;
      bus.mem_addr <= '0;
      bus.i_ack    <= 1'b0;
      bus.i_err    <= 1'b0;
      bus.i_rdata  <= '0;
      bus.d_ack    <= 1'b0;
      bus.d_err    <= 1'b0;
      bus.d_rdata  <= '0;
      bus.busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_req || bus.d_req) begin
            state        <= ACCESS;
            bus.busy     <= 1'b1;
            owner        <= grant_d ? PORT_D : PORT_I;
            last_grant   <= grant_d ? PORT_D : PORT_I;
            err_q        <= req_err;
            wdata_q      <= bus.d_wdata;
            be_q         <= req_store ? bus.d_be : '0;
            bus.mem_addr <= req_addr[ADDR_LEN+1:2];
            bus.mem_cs_n <= req_err;
            // An erroneous access must not select the array or write to it.
            bus.mem_we_n <= !req_full;
          end
        end
        ACCESS: begin
          state        <= DONE;
          bus.mem_cs_n <= 1'b1;
          bus.mem_we_n <= 1'b1;
          if (owner == PORT_D) begin
            bus.d_ack   <= 1'b1;
            bus.d_err   <= err_q;
            bus.d_rdata <= err_q ? '0 : bus.mem_rdata;
          end else begin
            bus.i_ack   <= 1'b1;
            bus.i_err   <= err_q;
            bus.i_rdata <= err_q ? '0 : bus.mem_rdata;
          end
        end
        DONE: begin
          state     <= IDLE;
          bus.busy  <= 1'b0;
          be_q      <= '0;
          bus.i_ack <= 1'b0;
          bus.i_err <= 1'b0;
          bus.d_ack <= 1'b0;
          bus.d_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural read-then-commit word array.
module tb_mem_arbiter;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned ADDR_LEN = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.XLEN(XLEN), .ADDR_LEN(ADDR_LEN)) bus ();

  mem_arbiter #(.XLEN(XLEN), .ADDR_LEN(ADDR_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Array model: read at negedge when selected, commit at posedge when selected or write-enabled.
  logic [31:0] mem [1024];
  always @(negedge clk) if (!bus.mem_cs_n) bus.mem_rdata <= mem[bus.mem_addr];
  always @(posedge clk) if (!bus.mem_cs_n || !bus.mem_we_n) mem[bus.mem_addr] <= bus.mem_wdata;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request from time posedge+1, hold until ack, then drop it and let DONE retire.
  task automatic access(input bit port_d, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err,
                        output int cycles, output int we_low, output int cs_low);
    cycles = 0; we_low = 0; cs_low = 0;
    if (port_d) begin
      bus.d_we = we; bus.d_be = be; bus.d_addr = addr; bus.d_wdata = wdata; bus.d_req = 1'b1;
    end else begin
      bus.i_addr = addr; bus.i_req = 1'b1;
    end
    do begin
      @(posedge clk); #1;
      cycles++;
      if (!bus.mem_we_n) we_low++;
      if (!bus.mem_cs_n) cs_low++;
    end while (!(port_d ? bus.d_ack : bus.i_ack) && cycles < 20);
    rdata = port_d ? bus.d_rdata : bus.i_rdata;
    err   = port_d ? bus.d_err : bus.i_err;
    bus.d_req = 1'b0;
    bus.i_req = 1'b0;
    @(posedge clk); #1;
    if (!bus.mem_we_n) we_low++;
    if (!bus.mem_cs_n) cs_low++;
  endtask

  logic [31:0] rd;
  logic        er;
  int          cy, wl, cl;
  int          ack_seen;
  int          ack_cyc[$];
  bit          ack_port[$];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    bus.mem_rdata = '0;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cs_n",  32'(bus.mem_cs_n), 32'd1);
    check("rst_we_n",  32'(bus.mem_we_n), 32'd1);
    check("rst_addr",  32'(bus.mem_addr), 32'd0);
    check("rst_acks",  {28'd0, bus.i_ack, bus.i_err, bus.d_ack, bus.d_err}, 32'd0);
    check("rst_irdat", bus.i_rdata, 32'd0);
    check("rst_drdat", bus.d_rdata, 32'd0);
    check("rst_busy",  32'(bus.busy), 32'd0);
    rst = 1'b0;

    // Reset in the middle of a full-word store must drop it without commit or ack.
    mem[16] = 32'hA5A5A5A5;
    bus.d_we = 1'b1; bus.d_be = 4'hF; bus.d_addr = 32'h40; bus.d_wdata = 32'hFFFFFFFF; bus.d_req = 1'b1;
    @(posedge clk); #1;
    check("midrst_cs_pre", 32'(bus.mem_cs_n), 32'd0);
    check("midrst_we_pre", 32'(bus.mem_we_n), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("midrst_cs",   32'(bus.mem_cs_n), 32'd1);
    check("midrst_we",   32'(bus.mem_we_n), 32'd1);
    check("midrst_addr", 32'(bus.mem_addr), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    bus.d_req = 1'b0;
    ack_seen = 0;
    repeat (2) begin @(posedge clk); #1; if (bus.d_ack) ack_seen++; end
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (bus.d_ack) ack_seen++; end
    check("midrst_noack", 32'(ack_seen), 32'd0);
    check("midrst_mem",   mem[16], 32'hA5A5A5A5);

    // Fetch.
    mem[4] = 32'hDEADBEEF;
    access(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, rd, er, cy, wl, cl);
    check("fetch_lat",   32'(cy), 32'd2);
    check("fetch_rdata", rd, 32'hDEADBEEF);
    check("fetch_err",   32'(er), 32'd0);
    check("fetch_we",    32'(wl), 32'd0);
    check("fetch_mem",   mem[4], 32'hDEADBEEF);

    // Full-word store then load.
    mem[8] = 32'h0BADF00D;
    access(1'b1, 1'b1, 4'hF, 32'h20, 32'h12345678, rd, er, cy, wl, cl);
    check("st_lat",   32'(cy), 32'd2);
    check("st_we1",   32'(wl), 32'd1);
    check("st_pre",   rd, 32'h0BADF00D);
    check("st_err",   32'(er), 32'd0);
    access(1'b1, 1'b0, 4'hF, 32'h20, 32'hFFFFFFFF, rd, er, cy, wl, cl);
    check("ld_rdata", rd, 32'h12345678);
    check("ld_we",    32'(wl), 32'd0);
    check("ld_mem",   mem[8], 32'h12345678);

    // Partial store merges lane 1 on the read-then-commit cycle.
    mem[8] = 32'h11223344;
    access(1'b1, 1'b1, 4'b0010, 32'h20, 32'h0000AB00, rd, er, cy, wl, cl);
    check("pst_we",  32'(wl), 32'd0);
    check("pst_cs",  32'(cl), 32'd1);
    check("pst_pre", rd, 32'h11223344);
    check("pst_mem", mem[8], 32'h1122AB44);

    // Misaligned and out-of-range loads.
    mem[0] = 32'hCAFE0000;
    access(1'b1, 1'b0, 4'h0, 32'h22, 32'h0, rd, er, cy, wl, cl);
    check("err1_lat", 32'(cy), 32'd2);
    check("err1_err", 32'(er), 32'd1);
    check("err1_rd",  rd, 32'd0);
    check("err1_cs",  32'(cl), 32'd0);
    access(1'b1, 1'b0, 4'h0, 32'h1000, 32'h0, rd, er, cy, wl, cl);
    check("err2_err", 32'(er), 32'd1);
    check("err2_rd",  rd, 32'd0);
    check("err2_cs",  32'(cl), 32'd0);
    check("err_mem8", mem[8], 32'h1122AB44);
    check("err_mem0", mem[0], 32'hCAFE0000);

    // Contention from reset: I wins first, then strict alternation every 3 cycles.
    @(posedge clk); #1;
    rst = 1'b1;
    bus.i_addr = 32'h10; bus.i_req = 1'b1;
    bus.d_we = 1'b0; bus.d_addr = 32'h20; bus.d_req = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (bus.i_ack) begin ack_cyc.push_back(k); ack_port.push_back(1'b0); end
      if (bus.d_ack) begin ack_cyc.push_back(k); ack_port.push_back(1'b1); end
    end
    check("cont_i_rdata", bus.i_rdata, 32'hDEADBEEF);
    check("cont_d_rdata", bus.d_rdata, 32'h1122AB44);
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    check("cont_count", 32'(ack_cyc.size()), 32'd4);
    for (int i = 0; i < ack_cyc.size() && i < 4; i++) begin
      check($sformatf("cont_cyc%0d", i),  32'(ack_cyc[i]), 32'(2 + 3 * i));
      check($sformatf("cont_port%0d", i), 32'(ack_port[i]), 32'(i % 2));
    end
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of the single-port synchronous `mem` word array. It shares the array between the core's instruction-fetch port (I) and load/store port (D). Each access is turned into a one-cycle memory command, with fair round-robin arbitration and alignment and range checking. Sub-word stores use the array's read-then-commit cycle, so there are no extra memory cycles.

## Interface
- `XLEN`, 32: data and byte-address width.
- `ADDR_LEN`, 10: memory word-address width. The legal byte range is 0 to 4*2^ADDR_LEN-1.
- `clk` in 1: the single clock. All state updates on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `i_req` in 1: fetch request. Hold it until `i_ack`.
- `i_addr` in XLEN: fetch byte address.
- `i_ack` out 1: one-cycle completion pulse.
- `i_err` out 1: error flag, valid with `i_ack`.
- `i_rdata` out XLEN: fetched word, valid with `i_ack`.
- `d_req` in 1: data request. Hold it until `d_ack`.
- `d_we` in 1: 1 selects store, 0 selects load.
- `d_be` in XLEN/8: store byte enables. Ignored for loads.
- `d_addr` in XLEN: data byte address.
- `d_wdata` in XLEN: store data, in lane position.
- `d_ack`, `d_err`, `d_rdata` out 1/1/XLEN: as for the I port. For a store, `d_rdata` is the pre-store word.
- `mem_addr` out ADDR_LEN: word address to the array.
- `mem_wdata` out XLEN: commit data to the array.
- `mem_cs_n` out 1: active-low chip select.
- `mem_we_n` out 1: active-low write enable.
- `mem_rdata` in XLEN: array read data. It updates on negedge of a selected cycle.
- `busy` out 1: high whenever state is not IDLE.

## Operation
- **Array property the design relies on.** The array commits `mem_wdata` at posedge whenever `mem_cs_n` or `mem_we_n` is low. It reads at the negedge of any cycle with `mem_cs_n` low.
  - So every selected cycle is a read followed by a commit.
  - Combinational rule: `mem_wdata` = merge(`mem_rdata`, latched wdata, latched byte enables).
  - Byte lane k takes wdata when be[k]=1, else `mem_rdata`.
  - Loads and fetches latch be=0. Their commit therefore writes the same word back and the contents are unchanged.
- **FSM: IDLE → ACCESS → DONE → IDLE.** ACCESS and DONE each last exactly one cycle.
- **IDLE**
  - Requests are sampled only here.
  - At posedge, if any request is present, pick the winner and latch its command: kind, word address = addr[ADDR_LEN+1:2], wdata, be. Then go to ACCESS.
  - Fetch latches be=0. A load latches be=0. A store latches `d_be`.
- **Arbitration**
  - If only one port requests, it wins.
  - If both request, the winner is the port not granted last.
  - `last_grant` resets to D, so the first tie goes to I.
- **Error check at grant**
  - An access is an error if addr[1:0]≠0, or if any addr bit at position ADDR_LEN+2 or above is set.
  - An error access still passes through ACCESS, but `mem_cs_n` stays 1 and the array is not touched.
- **ACCESS**
  - `mem_cs_n`=0 (unless error) and `mem_addr`=latched word address.
  - `mem_we_n`=0 only for a store with be all-ones; otherwise 1.
  - At posedge, capture `mem_rdata` into the winner's rdata register (0 if error).
  - Assert the winner's ack, plus err if error.
- **DONE**
  - ack/err are high for this single cycle. `mem_cs_n`=`mem_we_n`=1.
  - Next state is IDLE. A `req` still high during DONE is not a new request.
- **Requester obligations**
  - Keep the payload stable until ack. Payload is latched at grant, so later changes are ignored.
  - To issue back-to-back requests, keep `req` high after ack; it is sampled again in the next IDLE.
  - A losing requester keeps `req` high and is served next.
- **Reset values:** state IDLE, `mem_cs_n`=1, `mem_we_n`=1, `mem_addr`=0, all ack/err 0, `i_rdata`=`d_rdata`=0, `last_grant`=D, `busy`=0.

## Timing
- Request first seen at the posedge ending cycle T (in IDLE).
- ACCESS is cycle T+1. ack/err/rdata are valid in cycle T+2 (DONE).
- Earliest next grant is at the end of T+3. Per-port throughput is one access per 3 cycles.
- Both ports continuously requesting: grants alternate I, D, I, D…, one every 3 cycles.
- ack/err/rdata/`mem_*` are registered outputs. The only combinational output is `mem_wdata`.
- Reset asserted mid-access:
  - All outputs go to reset values immediately, so `mem_cs_n` rises before the next posedge.
  - The access is dropped, with no ack and no commit.
  - The requester must re-request after `rst` deasserts.
- Reset deasserted: the first grant can happen at the first posedge with `rst` low.

## Test plan
- **Reset:** pulse `rst` mid-ACCESS of a store of 0xFFFFFFFF to byte addr 0x40. Required:
  - outputs drop to reset values within the same cycle;
  - word 0x10 is unchanged;
  - no `d_ack` appears.
- **Fetch:** preload word 4 = 0xDEADBEEF; `i_req` with `i_addr`=0x10. Required:
  - `i_ack`=1 in T+2 with `i_rdata`=0xDEADBEEF and `i_err`=0;
  - word 4 is still 0xDEADBEEF afterwards.
- **Full store then load:** store `d_addr`=0x20, `d_be`=4'hF, `d_wdata`=0x12345678. Required: `mem_we_n` low for exactly one cycle, then a load returns 0x12345678.
- **Partial store:** word 8 = 0x11223344; store `d_addr`=0x20, `d_be`=4'b0010, `d_wdata`=0x0000AB00. Required:
  - `mem_we_n` stays 1;
  - `d_rdata`=0x11223344;
  - word 8 becomes 0x1122AB44.
- **Contention:** `i_req` and `d_req` both held from reset. Required: acks in order I, D, I, D, each 3 cycles apart, with the first `i_ack` 2 cycles after the first grant.
- **Errors:** load from `d_addr`=0x22, then from `d_addr`=0x1000 (ADDR_LEN=10). Required:
  - each gets `d_ack`=`d_err`=1 and `d_rdata`=0;
  - `mem_cs_n` never goes low;
  - memory is unchanged.
